fwd_regfile: RTL
================

# fwd_regfile

Parametrised pipelined register file with multi-port reads, multi-stage operand forwarding, load-use stall detection and held-operand patching. It generalises the processor's two-read/one-write register file and its hand-written bypass logic into one block. It sits between decode (read addresses) and the ALU stage (registered operands). Every in-flight producer stage and the writeback port feed it.

## Interface
Parameters:
- DBITS, 16, data width
- ABITS, 3, register address width; 2**ABITS registers
- NRD, 2, number of read ports
- NSTG, 2, number of in-flight producer stages tracked for forwarding; stage 0 is youngest
- MFILE, "Regs.mif", initial-content file, used by simulation only

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-high reset
- RADDR  in  NRD*ABITS  packed read addresses; port i occupies bits [i*ABITS +: ABITS]
- HOLD  in  1  pipeline freeze from downstream; DOUT is not reloaded
- DOUT  out  NRD*DBITS  registered read operands, same packing as RADDR
- STALL  out  1  combinational load-use hazard flag
- PWE  in  NSTG  producer stage s will write a register
- PADDR  in  NSTG*ABITS  destination register of each producer stage
- PDATA  in  NSTG*DBITS  result of each producer stage
- PRDY  in  NSTG  PDATA of stage s is valid; 0 means a load result is not yet available
- WE  in  1  commit write enable
- WADDR  in  ABITS  commit write address
- DIN  in  DBITS  commit write data

## Operation
- Array: 2**ABITS words. A commit write happens at posedge when WE=1.
- Source selection for read port i, computed combinationally from RADDR[i], in priority order:
  1. Lowest-index stage s with PWE[s]=1 and PADDR[s]==RADDR[i].
  2. The commit port, if WE=1 and WADDR==RADDR[i] (write-through).
  3. The array.
- If the winning source is a stage with PRDY[s]=0, port i is hazarded. STALL is the OR of all port hazards.
- Hazards from stages that lose on priority are ignored.
- DOUT load condition: DOUT[i] loads the selected value at posedge when HOLD=0 and STALL=0.
- Held-operand patching: when HOLD=1 or STALL=1, DOUT[i] keeps its value. Exception: if WE=1 and WADDR equals the address latched with DOUT[i], then DOUT[i] takes DIN.
  - This requires a per-port registered copy of the address.
- Simultaneous commit write and read of the same register returns DIN, never stale data.

## Timing
- Read latency: RADDR sampled at edge k; DOUT valid after edge k.
- Write latency: a commit at edge k is visible in the array from cycle k+1. It is also visible via write-through in cycle k.
- STALL is purely combinational. It is 0 whenever no matching producer has PRDY=0.
- RESET asserted:
  - All array words = 0.
  - DOUT = 0.
  - Latched addresses = 0.
  - STALL may be asserted only by live inputs.
- RESET deasserted mid-operation: the block resumes with zeroed state. There is no replay.
- Address wrap: none. Addresses are exact ABITS values.

## Configuration
- FWD_REGFILE_R0ZERO_EN defined:
  - Register 0 reads as 0 from every source.
  - Writes to 0 are discarded.
  - Producers with PADDR=0 never forward and never stall.
- Undefined: register 0 is an ordinary register.

## Structure
- Shared package holds:
  - Default DBITS/ABITS.
  - The function extracting field i from a packed bus.
  - The forwarding-source enum (FWD_STAGE, FWD_COMMIT, FWD_ARRAY), used for debug visibility.
- One sub-module, fwd_select:
  - Combinational priority mux for a single read port; instantiated NRD times.
  - Outputs the selected data and the hazard bit.
- The array, address latches and patch logic stay in the top.

## Test plan
- Reset, then read all 8 registers on both ports -> every DOUT = 0x0000; STALL = 0.
- Commit WADDR=3 DIN=0x1234 with RADDR0=3 in the same cycle -> DOUT0 = 0x1234 after the edge. The next read of 3 also gives 0x1234.
- Stage0 PADDR=3 PDATA=0xAAAA and stage1 PADDR=3 PDATA=0xBBBB, both PRDY=1, WE=1 WADDR=3 DIN=0xCCCC -> DOUT0 = 0xAAAA.
- Stage0 PWE=1 PADDR=5 PRDY=0 with RADDR1=5 -> STALL=1 and DOUT unchanged. Next cycle PRDY=1 PDATA=0x0F0F -> STALL=0 and DOUT1 = 0x0F0F.
- Load DOUT0 from register 2 = 0x0001, then HOLD=1 and commit WADDR=2 DIN=0x5555 -> DOUT0 = 0x5555 while HOLD remains 1.
- Commit WADDR=0 DIN=0xFFFF, then read 0 -> 0x0000 with FWD_REGFILE_R0ZERO_EN defined; 0xFFFF without it.

Source files
------------

// File: rtl/fwd_regfile_pkg.sv
// Shared types and helpers for the forwarding register file.
// FWD_REGFILE_R0ZERO_EN makes register 0 a hardwired zero.
package fwd_regfile_pkg;

  localparam int unsigned DEF_DBITS = 16;
  localparam int unsigned DEF_ABITS = 3;

  // Widest packed bus / field the extraction helper handles.
  localparam int unsigned BUS_MAX   = 1024;
  localparam int unsigned FIELD_MAX = 64;

`ifdef FWD_REGFILE_R0ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    FWD_STAGE  = 2'd0,
    FWD_COMMIT = 2'd1,
    FWD_ARRAY  = 2'd2
  } fwd_src_e;

  // Field idx of a packed bus made of width-bit fields; caller narrows the result.
  function automatic logic [FIELD_MAX-1:0] get_field(input logic [BUS_MAX-1:0] bus,
                                                     input int unsigned idx,
                                                     input int unsigned width);
    get_field = FIELD_MAX'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Single read-port priority mux: youngest matching producer, then commit
// write-through, then the array. Honors FWD_REGFILE_R0ZERO_EN via the package.
module fwd_select
  import fwd_regfile_pkg::*;
#(
  parameter int unsigned DBITS = DEF_DBITS,
  parameter int unsigned ABITS = DEF_ABITS,
  parameter int unsigned NSTG  = 2
) (
  input  logic [ABITS-1:0]      raddr,
  input  logic [NSTG-1:0]       pwe,
  input  logic [NSTG*ABITS-1:0] paddr,
  input  logic [NSTG*DBITS-1:0] pdata,
  input  logic [NSTG-1:0]       prdy,
  input  logic                  we,
  input  logic [ABITS-1:0]      waddr,
  input  logic [DBITS-1:0]      din,
  input  logic [DBITS-1:0]      arr_data,
  output logic [DBITS-1:0]      data_c,
  output logic                  hazard_c,
  output fwd_src_e              src_c
);

  logic [ABITS-1:0] stg_addr;

  // Lowest-priority source first; later overrides win, so stage 0 is applied last.
  always_comb begin
    data_c   = arr_data;
    hazard_c = 1'b0;
    src_c    = FWD_ARRAY;
    stg_addr = '0;

    if (we && (waddr == raddr)) begin
      data_c = din;
      src_c  = FWD_COMMIT;
    end

    for (int s = int'(NSTG) - 1; s >= 0; s--) begin
      stg_addr = ABITS'(get_field(BUS_MAX'(paddr), s, ABITS));
      if (pwe[s] && (stg_addr == raddr) && !(R0_ZERO && (stg_addr == '0))) begin
        data_c   = DBITS'(get_field(BUS_MAX'(pdata), s, DBITS));
        hazard_c = !prdy[s];
        src_c    = FWD_STAGE;
      end
    end

    if (R0_ZERO && (raddr == '0)) begin
      data_c   = '0;
      hazard_c = 1'b0;
      src_c    = FWD_ARRAY;
    end
  end

endmodule

// File: rtl/fwd_regfile.sv
// Pipelined register file with multi-stage forwarding, load-use stall and
// held-operand patching. Define FWD_REGFILE_R0ZERO_EN for a hardwired-zero r0.
module fwd_regfile
  import fwd_regfile_pkg::*;
#(
  parameter int unsigned DBITS = DEF_DBITS,
  parameter int unsigned ABITS = DEF_ABITS,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NSTG  = 2,
  parameter              MFILE = "Regs.mif"
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NRD*ABITS-1:0]  RADDR,
  input  logic                  HOLD,
  output logic [NRD*DBITS-1:0]  DOUT,
  output logic                  STALL,
  input  logic [NSTG-1:0]       PWE,
  input  logic [NSTG*ABITS-1:0] PADDR,
  input  logic [NSTG*DBITS-1:0] PDATA,
  input  logic [NSTG-1:0]       PRDY,
  input  logic                  WE,
  input  logic [ABITS-1:0]      WADDR,
  input  logic [DBITS-1:0]      DIN
);

  localparam int unsigned NREGS = 2 ** ABITS;

  logic [DBITS-1:0] mem [NREGS];
  logic [NRD-1:0]   port_stall;
  logic             commit_ok;
  logic             load;

  // Contents come from reset; the preload file only names the sim image.
  if (MFILE == "") begin : g_no_mfile
  end

  assign commit_ok = WE && !(R0_ZERO && (WADDR == '0));
  assign load      = !HOLD && !STALL;
  assign STALL     = |port_stall;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < int'(NREGS); r++) mem[r] <= '0;
    end else if (commit_ok) begin
      mem[WADDR] <= DIN;
    end
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_port
    logic [ABITS-1:0] raddr_i;
    logic [DBITS-1:0] sel_data;
    logic             hazard;
    fwd_src_e         sel_src;
    logic [DBITS-1:0] dout_q;
    logic [ABITS-1:0] laddr_q;

    assign raddr_i = ABITS'(get_field(BUS_MAX'(RADDR), i, ABITS));

    fwd_select #(
      .DBITS (DBITS),
      .ABITS (ABITS),
      .NSTG  (NSTG)
    ) u_sel (
      .raddr    (raddr_i),
      .pwe      (PWE),
      .paddr    (PADDR),
      .pdata    (PDATA),
      .prdy     (PRDY),
      .we       (commit_ok),
      .waddr    (WADDR),
      .din      (DIN),
      .arr_data (mem[raddr_i]),
      .data_c   (sel_data),
      .hazard_c (hazard),
      .src_c    (sel_src)
    );

    // Only a winning, not-yet-ready producer can freeze the pipe.
    assign port_stall[i] = hazard && (sel_src == FWD_STAGE);

    // Frozen operands still track commits to the register they were read from.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        dout_q  <= '0;
        laddr_q <= '0;
      end else if (load) begin
        dout_q  <= sel_data;
        laddr_q <= raddr_i;
      end else if (commit_ok && (WADDR == laddr_q)) begin
        dout_q  <= DIN;
      end
    end

    assign DOUT[i*DBITS +: DBITS] = dout_q;
  end

endmodule
